sccb_write_master: RTL and testbench
====================================

// Module: sccb_write_master
// PURPOSE
// - SCCB (I2C-compatible) 3-phase write master for the OV5640 camera.
// - Sits directly downstream of the register-initialisation sequencer, which presents one
//   {16-bit register address, 8-bit data} pair per start pulse and waits for done.
// - Drives the open-drain scl/sda pins and reports one-cycle completion plus a sticky NACK flag.
// PARAMETERS
// - CLK_DIV   63     meg25 cycles per quarter SCL period (63 -> ~99 kHz SCL); legal range 2..1023
// - DEV_ADDR  8'h78  8-bit write address (R/W bit = 0) sent as phase 1
// PORTS
// - meg25     in   1   system clock, 25 MHz; all logic on rising edge
// - rst_n     in   1   synchronous reset, active low
// - start     in   1   request; accepted on an edge where start=1 and busy=0
// - reg_addr  in   16  register address; captured at acceptance
// - reg_data  in   8   register data; captured at acceptance
// - busy      out  1   high from the cycle after acceptance until done
// - done      out  1   one-cycle pulse at transaction end
// - nack      out  1   sticky: 1 if any ack slot sampled sda=1; cleared at next acceptance
// - scl       out  1   SCCB clock; push-pull, idle high
// - sda       inout 1  open drain: sda = sda_low ? 1'b0 : 1'bz; read back for ack sampling
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): busy=0, done=0, nack=0, scl=1, sda released (z),
//   quarter counter=0, state=IDLE.
// - Reset mid-transfer: abort immediately, with no STOP and no done pulse.
// - Timing base: divider counts 0..CLK_DIV-1.
//   - A quarter ends on the cycle where the count = CLK_DIV-1; count then wraps to 0.
//   - The divider is held at 0 in IDLE.
// - FSM: IDLE -> START -> BITS -> STOP -> IDLE.
//   - IDLE: scl=1, sda z. On accept, latch {DEV_ADDR, reg_addr[15:8], reg_addr[7:0], reg_data}
//     into a 32-bit shift register, clear nack, and enter START.
//   - START (2 quarters): Q0 scl=1 sda z; Q1 scl=1 sda low (start condition).
//   - BITS (36 bits = 4 bytes x (8 data + 1 ack), MSB first, 4 quarters each):
//     - q0 scl=0, drive sda to the bit value (low, or z for a 1).
//     - q1 scl=0.
//     - q2 and q3 scl=1.
//     - sda changes only while scl=0.
//     - Ack slot (every 9th bit): master releases sda. sda is sampled on the last cycle of q2;
//       a sampled 1 sets nack.
//     - NACK does not abort. SCCB treats ack as don't-care, so all 4 phases are always sent.
//   - STOP (3 quarters): Q0 scl=0 sda low; Q1 scl=1 sda low; Q2 scl=1 sda z (stop condition).
// - Latency: fixed 149 quarters.
//   - done=1 for exactly one cycle, 149*CLK_DIV cycles after the accepting edge.
//   - busy=0 in that same cycle.
//   - The bus is idle (scl=1, sda z) from that cycle on.
// - Back-to-back transactions: start=1 in the done cycle is accepted (busy=0).
//   The bus then holds idle for a minimum of one full START Q0 quarter before the next start
//   condition.
// - start while busy=1: ignored, with no effect on inputs latched in flight.
// - reg_addr/reg_data changes after acceptance: no effect until the next acceptance.
// - X/z on the sda input outside ack slots is ignored.
// TESTING (CLK_DIV=4, 10k pull-up model on sda, 25 MHz meg25)
// 1. Reset: hold rst_n=0 for 3 cycles -> busy=0, done=0, nack=0, scl=1, sda=z.
// 2. Basic write: reg_addr=16'h3008, reg_data=8'h82, start pulse, ACKing slave model ->
//    - decoded bytes 78,30,08,82;
//    - done pulse exactly 596 cycles after acceptance; nack=0;
//    - sda never changes while scl=1 except at the start and stop conditions.
// 3. No slave (pull-up only): same write -> nack=1 after the first ack slot;
//    done still at 596 cycles; STOP still issued.
// 4. Start while busy: pulse start at cycle 100 of a transfer, with reg_addr=16'hFFFF ->
//    ignored; the bus carries only the original bytes; exactly one done.
// 5. Reset mid-transfer: drop rst_n at cycle 200 (inside byte 2) ->
//    - next cycle scl=1, sda=z, busy=0;
//    - no done pulse;
//    - a following start issues a complete, correct transaction.
// 6. Back-to-back: assert start in the done cycle with 16'h3103/8'h11 ->
//    - second transaction accepted; nack cleared;
//    - second done exactly 596 cycles after the first done.

Source files
------------

// File: rtl/sccb_write_master.sv
// SCCB three-phase write master for the OV5640: START, four bytes each followed by an
// ack slot, then STOP. Every transaction takes exactly 149 SCL quarter periods.
module sccb_write_master #(
    parameter int         CLK_DIV  = 63,
    parameter logic [7:0] DEV_ADDR = 8'h78
) (
    input  logic        meg25,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_data,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl,
    inout  wire         sda
);

    localparam logic [9:0] LAST_CNT = 10'(CLK_DIV - 1);
    localparam logic [9:0] DONE_CNT = 10'(CLK_DIV - 2);

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

    state_t      state;
    logic [9:0]  cnt;
    logic [1:0]  quarter;
    logic [3:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic        sda_low;
    logic        quarter_end;
    logic        accept;
    logic        ack_slot;

    assign sda         = sda_low ? 1'b0 : 1'bz;
    assign quarter_end = (cnt == LAST_CNT);
    assign accept      = start && !busy;
    assign ack_slot    = (bit_idx == 4'd8);

    // Outputs for a quarter are loaded on the edge that ends the previous quarter, so
    // scl/sda are plain registers. done is raised one cycle early so that it coincides
    // with the last cycle of STOP, letting a back-to-back start land on the quarter edge.
    always_ff @(posedge meg25) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            quarter  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            sda_low  <= 1'b0;
            scl      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state   <= START;
                cnt     <= '0;
                quarter <= '0;
                shreg   <= {DEV_ADDR, reg_addr, reg_data};
                nack    <= 1'b0;
                busy    <= 1'b1;
                scl     <= 1'b1;
                sda_low <= 1'b0;
            end else begin
                cnt <= (state == IDLE || quarter_end) ? '0 : cnt + 10'd1;
                unique case (state)
                    IDLE: begin
                        scl     <= 1'b1;
                        sda_low <= 1'b0;
                    end
                    START: begin
                        if (quarter_end) begin
                            if (quarter == 2'd0) begin
                                quarter <= 2'd1;
                                sda_low <= 1'b1;
                            end else begin
                                state    <= BITS;
                                quarter  <= 2'd0;
                                bit_idx  <= '0;
                                byte_idx <= '0;
                                scl      <= 1'b0;
                                sda_low  <= ~shreg[31];
                                shreg    <= {shreg[30:0], 1'b0};
                            end
                        end
                    end
                    BITS: begin
                        if (quarter_end) begin
                            quarter <= quarter + 2'd1;
                            case (quarter)
                                2'd1: scl <= 1'b1;
                                2'd2: begin
                                    if (ack_slot && sda) nack <= 1'b1;
                                end
                                2'd3: begin
                                    scl <= 1'b0;
                                    if (ack_slot && byte_idx == 2'd3) begin
                                        state   <= STOP;
                                        quarter <= 2'd0;
                                        sda_low <= 1'b1;
                                    end else if (ack_slot) begin
                                        bit_idx  <= '0;
                                        byte_idx <= byte_idx + 2'd1;
                                        sda_low  <= ~shreg[31];
                                        shreg    <= {shreg[30:0], 1'b0};
                                    end else begin
                                        bit_idx <= bit_idx + 4'd1;
                                        if (bit_idx == 4'd7) begin
                                            sda_low <= 1'b0;
                                        end else begin
                                            sda_low <= ~shreg[31];
                                            shreg   <= {shreg[30:0], 1'b0};
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    STOP: begin
                        if (quarter == 2'd2 && cnt == DONE_CNT) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                        if (quarter_end) begin
                            case (quarter)
                                2'd0: begin
                                    scl     <= 1'b1;
                                    quarter <= 2'd1;
                                end
                                2'd1: begin
                                    sda_low <= 1'b0;
                                    quarter <= 2'd2;
                                end
                                default: begin
                                    state   <= IDLE;
                                    quarter <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench for sccb_write_master: a bus monitor decodes scl/sda into bytes,
// an optional slave model drives acks, and each test compares against timing rules.
module tb_sccb_write_master;

    localparam int CLK_DIV = 4;
    localparam int TXN     = 149 * CLK_DIV;
    localparam int ACK0    = 37 * CLK_DIV;

    logic        meg25    = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] reg_addr = 16'h0000;
    logic [7:0]  reg_data = 8'h00;
    logic        busy;
    logic        done;
    logic        nack;
    logic        scl;
    wire         sda;

    logic slave_low = 1'b0;
    bit   slave_ack = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #20 meg25 = ~meg25;

    sccb_write_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h78)) dut (
        .meg25    (meg25),
        .rst_n    (rst_n),
        .start    (start),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .busy     (busy),
        .done     (done),
        .nack     (nack),
        .scl      (scl),
        .sda      (sda)
    );

    int checks = 0;
    int errors = 0;

    int   n_start = 0;
    int   n_stop  = 0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic sda_v;
    logic bits[$];

    int r_done_cycle, r_n_done, r_busy_bad, r_nack_bad, r_idle_bad;

    // Bus monitor plus slave: bits are captured on scl rising, the slave pulls sda low
    // for the slot following every eighth captured bit of a byte.
    always @(negedge meg25) begin
        sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (!rst_n) begin
            slave_low = 1'b0;
        end else begin
            if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda && !sda_v) begin
                n_start++;
                bits.delete();
            end
            if (prev_scl === 1'b1 && scl === 1'b1 && !prev_sda && sda_v) n_stop++;
            if (prev_scl === 1'b0 && scl === 1'b1) bits.push_back(sda_v);
            if (prev_scl === 1'b1 && scl === 1'b0)
                slave_low = slave_ack && (bits.size() % 9 == 8);
        end
        prev_scl = scl;
        prev_sda = sda_v;
    end

    task automatic decode(output logic [31:0] w, output logic [3:0] a);
        w = 'x;
        a = 'x;
        if (bits.size() >= 36) begin
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 8; b++) w[31 - 8*k - b] = bits[9*k + b];
                a[3 - k] = bits[9*k + 8];
            end
        end
    endtask

    task automatic accept_txn(input logic [15:0] a, input logic [7:0] d, input bit at_once);
        if (!at_once) @(negedge meg25);
        start    = 1'b1;
        reg_addr = a;
        reg_data = d;
        n_start  = 0;
        n_stop   = 0;
        bits.delete();
        @(posedge meg25);
        #1 start = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accepting edge; done belongs in cycle TXN.
    task automatic run_txn(input bit exp_nack, input int ncycles, input int poke_cycle,
                           input bit stop_at_done);
        r_done_cycle = 0; r_n_done = 0; r_busy_bad = 0; r_nack_bad = 0; r_idle_bad = 0;
        for (int c = 1; c <= ncycles; c++) begin
            @(negedge meg25);
            if (done === 1'b1) begin
                r_n_done++;
                if (r_done_cycle == 0) r_done_cycle = c;
            end
            if (busy !== (c < TXN)) r_busy_bad++;
            if (nack !== (exp_nack && c > ACK0)) r_nack_bad++;
            if (c >= TXN && (scl !== 1'b1 || sda === 1'b0)) r_idle_bad++;
            if (c == 1) begin
                reg_addr = 16'($urandom);
                reg_data = 8'($urandom);
            end
            if (c == poke_cycle) begin
                start    = 1'b1;
                reg_addr = 16'hFFFF;
            end
            if (c == poke_cycle + 1) start = 1'b0;
            if (stop_at_done && c == TXN && done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge meg25);
        @(negedge meg25);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset.done: got %b, expected 0", done); end
        checks++; if (nack !== 1'b0) begin errors++; $display("[TB] FAIL reset.nack: got %b, expected 0", nack); end
        checks++; if (scl !== 1'b1) begin errors++; $display("[TB] FAIL reset.scl: got %b, expected 1", scl); end
        checks++; if (sda === 1'b0) begin errors++; $display("[TB] FAIL reset.sda: got driven low, expected released"); end
        rst_n = 1'b1;
        repeat (3) @(negedge meg25);
    endtask

    task automatic test_basic_write();
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] w;
        logic [3:0]  k;
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 16'h3008 : 16'($urandom);
            d = (t == 0) ? 8'h82 : 8'($urandom);
            slave_ack = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            accept_txn(a, d, 1'b0);
            run_txn(!slave_ack, TXN + 8, 0, 1'b0);
            decode(w, k);
            checks++; if (w !== {8'h78, a, d}) begin errors++; $display("[TB] FAIL basic.bytes[%0d]: got %h, expected %h", t, w, {8'h78, a, d}); end
            checks++; if (k !== (slave_ack ? 4'b0000 : 4'b1111)) begin errors++; $display("[TB] FAIL basic.acks[%0d]: got %b", t, k); end
            checks++; if (r_done_cycle !== TXN) begin errors++; $display("[TB] FAIL basic.done_cycle[%0d]: got %0d, expected %0d", t, r_done_cycle, TXN); end
            checks++; if (r_n_done !== 1) begin errors++; $display("[TB] FAIL basic.done_count[%0d]: got %0d, expected 1", t, r_n_done); end
            checks++; if (r_busy_bad !== 0) begin errors++; $display("[TB] FAIL basic.busy[%0d]: %0d bad cycles, expected 0", t, r_busy_bad); end
            checks++; if (r_nack_bad !== 0) begin errors++; $display("[TB] FAIL basic.nack[%0d]: %0d bad cycles, expected 0", t, r_nack_bad); end
            checks++; if (r_idle_bad !== 0) begin errors++; $display("[TB] FAIL basic.idle[%0d]: %0d bad cycles, expected 0", t, r_idle_bad); end
            checks++; if (n_start !== 1 || n_stop !== 1) begin errors++; $display("[TB] FAIL basic.conditions[%0d]: got %0d starts %0d stops, expected 1 and 1", t, n_start, n_stop); end
            checks++; if (bits.size() !== 37) begin errors++; $display("[TB] FAIL basic.scl_pulses[%0d]: got %0d, expected 37", t, bits.size()); end
        end
    endtask

    task automatic test_no_slave();
        logic [31:0] w;
        logic [3:0]  k;
        slave_ack = 1'b0;
        accept_txn(16'h3008, 8'h82, 1'b0);
        run_txn(1'b1, TXN + 8, 0, 1'b0);
        decode(w, k);
        checks++; if (k !== 4'b1111) begin errors++; $display("[TB] FAIL noslave.acks: got %b, expected 1111", k); end
        checks++; if (r_nack_bad !== 0) begin errors++; $display("[TB] FAIL noslave.nack_timing: %0d bad cycles, expected 0", r_nack_bad); end
        checks++; if (nack !== 1'b1) begin errors++; $display("[TB] FAIL noslave.nack_final: got %b, expected 1", nack); end
        checks++; if (r_done_cycle !== TXN) begin errors++; $display("[TB] FAIL noslave.done_cycle: got %0d, expected %0d", r_done_cycle, TXN); end
        checks++; if (n_stop !== 1) begin errors++; $display("[TB] FAIL noslave.stop: got %0d, expected 1", n_stop); end
        checks++; if (w !== 32'h7830_0882) begin errors++; $display("[TB] FAIL noslave.bytes: got %h, expected 78300882", w); end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] w;
        logic [3:0]  k;
        a = 16'($urandom);
        d = 8'($urandom);
        slave_ack = 1'b1;
        accept_txn(a, d, 1'b0);
        run_txn(1'b0, TXN + 8, 100, 1'b0);
        decode(w, k);
        checks++; if (w !== {8'h78, a, d}) begin errors++; $display("[TB] FAIL busy_start.bytes: got %h, expected %h", w, {8'h78, a, d}); end
        checks++; if (r_n_done !== 1) begin errors++; $display("[TB] FAIL busy_start.done_count: got %0d, expected 1", r_n_done); end
        checks++; if (r_done_cycle !== TXN) begin errors++; $display("[TB] FAIL busy_start.done_cycle: got %0d, expected %0d", r_done_cycle, TXN); end
        checks++; if (r_busy_bad !== 0) begin errors++; $display("[TB] FAIL busy_start.busy: %0d bad cycles, expected 0", r_busy_bad); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] w;
        logic [3:0]  k;
        int          stray_done;
        slave_ack = 1'b1;
        accept_txn(16'h3008, 8'h82, 1'b0);
        repeat (200) @(negedge meg25);
        rst_n = 1'b0;
        @(negedge meg25);
        checks++; if (scl !== 1'b1) begin errors++; $display("[TB] FAIL midreset.scl: got %b, expected 1", scl); end
        checks++; if (sda === 1'b0) begin errors++; $display("[TB] FAIL midreset.sda: got driven low, expected released"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset.busy: got %b, expected 0", busy); end
        rst_n = 1'b1;
        stray_done = 0;
        for (int c = 0; c < TXN; c++) begin
            @(negedge meg25);
            if (done === 1'b1) stray_done++;
        end
        checks++; if (stray_done !== 0) begin errors++; $display("[TB] FAIL midreset.no_done: got %0d pulses, expected 0", stray_done); end
        a = 16'($urandom);
        d = 8'($urandom);
        accept_txn(a, d, 1'b0);
        run_txn(1'b0, TXN + 8, 0, 1'b0);
        decode(w, k);
        checks++; if (w !== {8'h78, a, d}) begin errors++; $display("[TB] FAIL midreset.next_bytes: got %h, expected %h", w, {8'h78, a, d}); end
        checks++; if (r_done_cycle !== TXN) begin errors++; $display("[TB] FAIL midreset.next_done: got %0d, expected %0d", r_done_cycle, TXN); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] w;
        logic [3:0]  k;
        a = 16'($urandom);
        d = 8'($urandom);
        slave_ack = 1'b0;
        accept_txn(a, d, 1'b0);
        run_txn(1'b1, TXN, 0, 1'b1);
        decode(w, k);
        checks++; if (r_done_cycle !== TXN) begin errors++; $display("[TB] FAIL b2b.first_done: got %0d, expected %0d", r_done_cycle, TXN); end
        checks++; if (w !== {8'h78, a, d}) begin errors++; $display("[TB] FAIL b2b.first_bytes: got %h, expected %h", w, {8'h78, a, d}); end
        slave_ack = 1'b1;
        accept_txn(16'h3103, 8'h11, 1'b1);
        run_txn(1'b0, TXN + 8, 0, 1'b0);
        decode(w, k);
        checks++; if (r_done_cycle !== TXN) begin errors++; $display("[TB] FAIL b2b.second_done: got %0d, expected %0d", r_done_cycle, TXN); end
        checks++; if (r_nack_bad !== 0) begin errors++; $display("[TB] FAIL b2b.nack_cleared: %0d bad cycles, expected 0", r_nack_bad); end
        checks++; if (w !== 32'h7831_0311) begin errors++; $display("[TB] FAIL b2b.second_bytes: got %h, expected 78310311", w); end
        checks++; if (n_start !== 1 || n_stop !== 1) begin errors++; $display("[TB] FAIL b2b.conditions: got %0d starts %0d stops, expected 1 and 1", n_start, n_stop); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_no_slave();
        test_start_while_busy();
        test_reset_mid_transfer();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
